// File: rtl/exhaustive_stim_capture.sv
// rtl/exhaustive_stim_capture.sv - exhaustive stimulus sweep with response capture, record stream and MISR
// Applies every pattern 0..2^N_IN-1, samples the DUT after SETTLE cycles, streams {pattern,response}.
module exhaustive_stim_capture #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 1
) (
  input  logic                    CK,
  input  logic                    reset,
  input  logic                    start,
  output logic [N_IN-1:0]         stim,
  input  logic [N_OUT-1:0]        dut_out,
  output logic                    busy,
  output logic                    done,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [N_IN+N_OUT-1:0]   rec_data,
  output logic                    rec_last,
  output logic [15:0]             signature
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_EMIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  settle_cnt;
  logic        settle_end;
  logic        at_last;
  logic [15:0] resp_ext;
  logic [15:0] sig_nxt;

  assign settle_end = (settle_cnt == 8'(SETTLE - 1));
  assign at_last    = &stim;

  // Only the low 16 response bits fit the signature register.
  generate
    if (N_OUT >= 16) begin : g_fold_wide
      assign resp_ext = dut_out[15:0];
    end else begin : g_fold_narrow
      assign resp_ext = {{(16 - N_OUT){1'b0}}, dut_out};
    end
  endgenerate

  assign sig_nxt = {signature[14:0], 1'b0}
                 ^ (signature[15] ? 16'h1021 : 16'h0000)
                 ^ resp_ext;

  always_ff @(posedge CK) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start)      state_nxt = S_APPLY;
      S_APPLY:        if (settle_end) state_nxt = S_EMIT;
      S_EMIT:         if (rec_ready)  state_nxt = rec_last ? S_DONE : S_APPLY;
      default:                        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == S_APPLY) || (state == S_EMIT);
    done      = (state == S_DONE);
    rec_valid = (state == S_EMIT);
  end

  always_ff @(posedge CK) begin
    if (!reset) begin
      stim       <= '0;
      settle_cnt <= 8'd0;
      rec_data   <= '0;
      rec_last   <= 1'b0;
      signature  <= 16'h0000;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            stim       <= '0;
            settle_cnt <= 8'd0;
            signature  <= 16'h0000;
          end
        end
        S_APPLY: begin
          if (settle_end) begin
            rec_data   <= {stim, dut_out};
            rec_last   <= at_last;
            signature  <= sig_nxt;
            settle_cnt <= 8'd0;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        S_EMIT: begin
          // The counter stops at all-ones; the final handshake moves to DONE instead.
          if (rec_ready && !rec_last) begin
            stim <= stim + {{(N_IN - 1){1'b0}}, 1'b1};
          end
        end
        default: begin
          stim <= stim;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exhaustive_stim_capture.sv
// tb/tb_exhaustive_stim_capture.sv - directed scoreboard bench for exhaustive_stim_capture
module tb_exhaustive_stim_capture;

  logic        CK = 1'b0;
  logic        reset;
  logic        tie_one;

  logic        start_a, busy_a, done_a, rv_a, rr_a, rl_a, dut_a;
  logic [3:0]  stim_a;
  logic [4:0]  rd_a;
  logic [15:0] sig_a;

  logic        start_b, busy_b, done_b, rv_b, rr_b, rl_b, dut_b;
  logic [3:0]  stim_b;
  logic [4:0]  rd_b;
  logic [15:0] sig_b;
  logic        d1_b, d2_b;

  int          checks = 0;
  int          failures = 0;
  logic [5:0]  q_a[$];
  logic [5:0]  q_b[$];

  always #5 CK = ~CK;

  assign dut_a = tie_one ? 1'b1 : ^stim_a;

  // Second DUT model answers two clocks late.
  always @(posedge CK) begin
    d1_b <= ^stim_b;
    d2_b <= d1_b;
  end
  assign dut_b = d2_b;

  exhaustive_stim_capture #(.N_IN(4), .N_OUT(1), .SETTLE(1)) u_a (
    .CK(CK), .reset(reset), .start(start_a), .stim(stim_a), .dut_out(dut_a),
    .busy(busy_a), .done(done_a), .rec_valid(rv_a), .rec_ready(rr_a),
    .rec_data(rd_a), .rec_last(rl_a), .signature(sig_a)
  );

  exhaustive_stim_capture #(.N_IN(4), .N_OUT(1), .SETTLE(3)) u_b (
    .CK(CK), .reset(reset), .start(start_b), .stim(stim_b), .dut_out(dut_b),
    .busy(busy_b), .done(done_b), .rec_valid(rv_b), .rec_ready(rr_b),
    .rec_data(rd_b), .rec_last(rl_b), .signature(sig_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic d);
    logic [15:0] r;
    r = {s[14:0], 1'b0};
    if (s[15]) r = r ^ 16'h1021;
    return r ^ {15'd0, d};
  endfunction

  // Pushes the 16 expected records and returns the expected final signature.
  task automatic push_sweep(input bit to_b, input bit ones, output logic [15:0] sig);
    logic [3:0] pv;
    logic       resp;
    sig = 16'h0000;
    for (int p = 0; p < 16; p++) begin
      pv   = 4'(p);
      resp = ones ? 1'b1 : ^pv;
      sig  = misr_step(sig, resp);
      if (to_b) q_b.push_back({pv == 4'hF, pv, resp});
      else      q_a.push_back({pv == 4'hF, pv, resp});
    end
  endtask

  always @(negedge CK) begin
    if (reset && rv_a && rr_a) begin
      if (q_a.size() == 0) check("a_extra_record", 32'(q_a.size()), 32'd1);
      else begin
        logic [5:0] e;
        e = q_a.pop_front();
        check("a_rec_data", 32'(rd_a), 32'(e[4:0]));
        check("a_rec_last", 32'(rl_a), 32'(e[5]));
      end
    end
    if (reset && rv_b && rr_b) begin
      if (q_b.size() == 0) check("b_extra_record", 32'(q_b.size()), 32'd1);
      else begin
        logic [5:0] e;
        e = q_b.pop_front();
        check("b_rec_data", 32'(rd_b), 32'(e[4:0]));
        check("b_rec_last", 32'(rl_b), 32'(e[5]));
      end
    end
  end

  task automatic pulse_start(input bit to_b);
    @(posedge CK); #1;
    if (to_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge CK); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Counts clocks from the first APPLY cycle until done; a midway start pulse is optional.
  task automatic wait_done(input bit to_b, input int poke_at, output int cyc);
    cyc = 0;
    while (!(to_b ? done_b : done_a) && cyc < 300) begin
      @(posedge CK); #1;
      cyc++;
      if (to_b) start_b = (cyc == poke_at);
      else      start_a = (cyc == poke_at);
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  initial begin
    int          cyc;
    int          guard;
    logic [15:0] exp_sig;
    logic [15:0] first_sig;

    reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
    rr_a = 1'b1; rr_b = 1'b1; tie_one = 1'b0;
    repeat (2) @(posedge CK);
    #1 reset = 1'b1;
    @(negedge CK);
    check("init_busy", 32'(busy_a), 32'd0);
    check("init_done", 32'(done_a), 32'd0);
    check("init_valid", 32'(rv_a), 32'd0);
    check("init_sig", 32'(sig_a), 32'd0);

    // Reset in the middle of a sweep
    push_sweep(1'b0, 1'b0, exp_sig);
    pulse_start(1'b0);
    repeat (9) @(posedge CK);
    #1 reset = 1'b0;
    repeat (2) @(posedge CK);
    #1 reset = 1'b1;
    q_a.delete();
    @(negedge CK);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_valid", 32'(rv_a), 32'd0);
    check("rst_last", 32'(rl_a), 32'd0);
    check("rst_stim", 32'(stim_a), 32'd0);
    check("rst_data", 32'(rd_a), 32'd0);
    check("rst_sig", 32'(sig_a), 32'd0);

    // Full parity sweep, with a start pulse that must be ignored mid-sweep
    push_sweep(1'b0, 1'b0, exp_sig);
    pulse_start(1'b0);
    check("sweep_first_busy", 32'(busy_a), 32'd1);
    check("sweep_first_stim", 32'(stim_a), 32'd0);
    wait_done(1'b0, 10, cyc);
    check("sweep_cycles", 32'(cyc), 32'd32);
    check("sweep_done", 32'(done_a), 32'd1);
    check("sweep_all_records", 32'(q_a.size()), 32'd0);
    check("sweep_sig", 32'(sig_a), 32'(exp_sig));
    check("done_stim_held", 32'(stim_a), 32'hF);
    check("done_valid_low", 32'(rv_a), 32'd0);

    // Signature over all-ones responses, started from DONE, then repeated
    tie_one = 1'b1;
    push_sweep(1'b0, 1'b1, exp_sig);
    pulse_start(1'b0);
    check("restart_done_clear", 32'(done_a), 32'd0);
    check("restart_stim", 32'(stim_a), 32'd0);
    wait_done(1'b0, 0, cyc);
    check("ones_sig", 32'(sig_a), 32'(exp_sig));
    first_sig = sig_a;
    push_sweep(1'b0, 1'b1, exp_sig);
    pulse_start(1'b0);
    wait_done(1'b0, 0, cyc);
    check("ones_sig_rerun", 32'(sig_a), 32'(first_sig));
    check("ones_records", 32'(q_a.size()), 32'd0);

    // Backpressure on pattern 6
    tie_one = 1'b0;
    push_sweep(1'b0, 1'b0, exp_sig);
    pulse_start(1'b0);
    guard = 0;
    @(negedge CK);
    while (!(stim_a == 4'd6 && !rv_a) && guard < 100) begin
      @(negedge CK);
      guard++;
    end
    check("bp_reach_pattern6", 32'(guard < 100), 32'd1);
    @(posedge CK); #1 rr_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CK);
      check("bp_valid_held", 32'(rv_a), 32'd1);
      check("bp_data_held", 32'(rd_a), 32'b01100);
      check("bp_stim_held", 32'(stim_a), 32'd6);
    end
    @(posedge CK); #1 rr_a = 1'b1;
    wait_done(1'b0, 0, cyc);
    check("bp_done", 32'(done_a), 32'd1);
    check("bp_records", 32'(q_a.size()), 32'd0);
    check("bp_sig", 32'(sig_a), 32'(exp_sig));

    // SETTLE=3 instance with a two-cycle response delay
    push_sweep(1'b1, 1'b0, exp_sig);
    pulse_start(1'b1);
    wait_done(1'b1, 0, cyc);
    check("s3_cycles", 32'(cyc), 32'd64);
    check("s3_records", 32'(q_b.size()), 32'd0);
    check("s3_sig", 32'(sig_b), 32'(exp_sig));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
